// File: rtl/inst_fetch_pkg.sv
// inst_fetch_pkg: shared widths, reset default and the prefetch-buffer entry
// type for the instruction fetch stage (also visible to decode/execute).
package inst_fetch_pkg;

  localparam int unsigned INST_W = 16;
  localparam int unsigned ADDR_W = 16;

  localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 16'h0000;

  // One buffered fetch result: the word and the address it came from.
  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

endpackage : inst_fetch_pkg

// File: rtl/fetch_buf.sv
// fetch_buf: circular FIFO of {pc, inst} entries with a registered head.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   push_i/push_data_i  write one entry at the tail
//   pop_i             drop the head entry
//   flush_i           empty the FIFO (overrides push/pop); head value holds
//   count_o           number of stored entries
//   valid_o, head_o   registered head entry and its valid flag
module fetch_buf
  import inst_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push_i,
  input  fetch_entry_t                 push_data_i,
  input  logic                         pop_i,
  input  logic                         flush_i,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         valid_o,
  output fetch_entry_t                 head_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  fetch_entry_t             mem_q [DEPTH];
  fetch_entry_t             mem_d [DEPTH];
  logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]         count_q, count_d;
  logic                     valid_q, valid_d;
  fetch_entry_t             head_q, head_d;

  // Next FIFO state; the head register is refreshed from the post-update
  // storage so a push into an empty FIFO is visible next cycle.
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    valid_d  = valid_q;
    head_d   = head_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      valid_d  = 1'b0;
    end else begin
      if (push_i) begin
        mem_d[wr_ptr_q] = push_data_i;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop_i) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
      valid_d = (count_d != '0);
      // An empty FIFO keeps showing its last head value.
      if (valid_d) begin
        head_d = mem_d[rd_ptr_d];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      head_q   <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      head_q   <= head_d;
    end
  end

  assign count_o = count_q;
  assign valid_o = valid_q;
  assign head_o  = head_q;

endmodule : fetch_buf

// File: rtl/inst_fetch.sv
// inst_fetch: instruction fetch stage. Holds the fetch PC, issues reads to
// the synchronous instruction memory, captures returning words into a
// prefetch buffer and hands them to decode with valid/ready. A branch
// redirect flushes all in-flight work and restarts fetch at the target.
// Optional macro INST_FETCH_BYPASS_EN: when the buffer is empty, a returning
// word is presented to decode in its capture cycle (1-cycle latency,
// combinational head outputs).
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   mem_ren, mem_addr, mem_rdata  instruction memory read port
//   br_taken, br_target           redirect from execute
//   inst_valid, inst_ready        decode handshake
//   inst_out, pc_out              head instruction and its word address
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int unsigned       BUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_ren,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [INST_W-1:0] mem_rdata,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst_out,
  output logic [ADDR_W-1:0] pc_out
);

  localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int unsigned OCC_W = CNT_W + 1;

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;

  logic [CNT_W-1:0]  buf_count;
  logic              buf_valid;
  fetch_entry_t      buf_head;
  fetch_entry_t      cap_entry;
  logic              buf_push;
  logic              buf_pop;
  logic              xfer;
  logic [OCC_W-1:0]  occ;

  assign cap_entry = '{pc: pend_pc_q, inst: mem_rdata};
  assign xfer      = inst_valid & inst_ready & ~br_taken;

`ifdef INST_FETCH_BYPASS_EN
  logic byp;

  // Word arriving into an empty buffer goes straight to decode.
  assign byp        = (buf_count == '0) & pend_q & ~br_taken & ~rst;
  assign inst_valid = ~rst & (buf_valid | byp);
  assign inst_out   = rst ? '0 : (byp ? mem_rdata : buf_head.inst);
  assign pc_out     = rst ? '0 : (byp ? pend_pc_q : buf_head.pc);
  // A bypassed word consumed this cycle is never stored.
  assign buf_push   = pend_q & ~br_taken & ~(byp & inst_ready);
  assign buf_pop    = xfer & ~byp;
`else
  assign inst_valid = buf_valid;
  assign inst_out   = buf_head.inst;
  assign pc_out     = buf_head.pc;
  assign buf_push   = pend_q & ~br_taken;
  assign buf_pop    = xfer;
`endif

  // Words held or in flight after this cycle's pop; issue only if one more fits.
  assign occ = OCC_W'(buf_count) + OCC_W'(pend_q) - OCC_W'(xfer);

  // Issue / redirect decision and next fetch state.
  always_comb begin
    mem_ren    = 1'b0;
    mem_addr   = fetch_pc_q;
    fetch_pc_d = fetch_pc_q;
    pend_d     = 1'b0;
    pend_pc_d  = pend_pc_q;
    if (br_taken) begin
      mem_ren    = 1'b1;
      mem_addr   = br_target;
      fetch_pc_d = br_target + ADDR_W'(1);
      pend_d     = 1'b1;
      pend_pc_d  = br_target;
    end else if (occ < OCC_W'(BUF_DEPTH)) begin
      mem_ren    = 1'b1;
      fetch_pc_d = fetch_pc_q + ADDR_W'(1);
      pend_d     = 1'b1;
      pend_pc_d  = fetch_pc_q;
    end
    // Memory must see no reads while it loads its image.
    if (rst) begin
      mem_ren = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      pend_q     <= 1'b0;
      pend_pc_q  <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      pend_q     <= pend_d;
      pend_pc_q  <= pend_pc_d;
    end
  end

  fetch_buf #(
    .DEPTH (BUF_DEPTH)
  ) u_fetch_buf (
    .clk         (clk),
    .rst         (rst),
    .push_i      (buf_push),
    .push_data_i (cap_entry),
    .pop_i       (buf_pop),
    .flush_i     (br_taken),
    .count_o     (buf_count),
    .valid_o     (buf_valid),
    .head_o      (buf_head)
  );

endmodule : inst_fetch

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: drives inst_fetch against a synchronous instruction memory
// and checks every cycle against a word-stream reference model: fetch
// addresses run sequentially from the last restart point, each issued word
// becomes visible a fixed latency after issue, at most two words may be
// buffered or in flight, and decode sees exactly the restart sequence.
module tb_inst_fetch;

`ifdef INST_FETCH_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif
  localparam int          DEPTH    = 2;
  localparam logic [15:0] RST_PC   = 16'h0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        br_taken = 1'b0;
  logic [15:0] br_target = '0;
  logic        inst_ready = 1'b0;
  logic        mem_ren;
  logic [15:0] mem_addr;
  logic [15:0] mem_rdata;
  logic        inst_valid;
  logic [15:0] inst_out;
  logic [15:0] pc_out;

  always #5 clk = ~clk;

  // Instruction memory: registered read address, held while ren is low.
  logic [15:0] mem [65536];
  logic [15:0] raddr = '0;
  always @(posedge clk) if (mem_ren) raddr <= mem_addr;
  assign mem_rdata = mem[raddr];

  inst_fetch dut (
    .clk        (clk),
    .rst        (rst),
    .mem_ren    (mem_ren),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .inst_out   (inst_out),
    .pc_out     (pc_out)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc   = 0;
  int          iss_q [$];      // issue cycle of each word not yet consumed
  logic [15:0] next_pc  = RST_PC;  // next address decode should receive
  logic [15:0] issue_pc = RST_PC;  // next address fetch should request
  logic        prev_rst = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  // One clock: apply inputs after the edge, check at the falling edge, then
  // advance the model to the next edge.
  task automatic step(input logic r, input logic b, input logic [15:0] tgt, input logic rdy);
    logic        ev;
    logic        pop;
    logic        eren;
    logic [15:0] eaddr;
    @(posedge clk);
    #1;
    rst        = r;
    br_taken   = b;
    br_target  = tgt;
    inst_ready = rdy;
    @(negedge clk);

    ev = !r && (iss_q.size() > 0) && (iss_q[0] <= cyc - LAT);
    // Registered head still reflects pre-reset state in the first reset cycle.
    if (!(r && !prev_rst)) chk("inst_valid", 32'(inst_valid), 32'(ev));
    if (ev) begin
      chk("pc_out", 32'(pc_out), 32'(next_pc));
      chk("inst_out", 32'(inst_out), 32'(mem[next_pc]));
    end
    if (r && prev_rst) begin
      chk("pc_out_rst", 32'(pc_out), 32'h0);
      chk("inst_out_rst", 32'(inst_out), 32'h0);
    end

    pop   = ev && rdy && !b;
    eren  = !r && (b || ((iss_q.size() - int'(pop)) < DEPTH));
    eaddr = b ? tgt : issue_pc;
    chk("mem_ren", 32'(mem_ren), 32'(eren));
    if (eren) chk("mem_addr", 32'(mem_addr), 32'(eaddr));

    if (r) begin
      iss_q.delete();
      next_pc  = RST_PC;
      issue_pc = RST_PC;
    end else if (b) begin
      iss_q.delete();
      iss_q.push_back(cyc);
      next_pc  = tgt;
      issue_pc = tgt + 16'd1;
    end else begin
      if (pop) begin
        void'(iss_q.pop_front());
        next_pc = next_pc + 16'd1;
      end
      if (eren) begin
        iss_q.push_back(cyc);
        issue_pc = issue_pc + 16'd1;
      end
    end
    prev_rst = r;
    cyc++;
  endtask

  initial begin
    logic        r_r;
    logic        r_b;
    logic        r_y;
    logic [15:0] r_t;
    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
    mem[0]        = 16'h1111;
    mem[1]        = 16'h2222;
    mem[2]        = 16'h3333;
    mem[16'h0040] = 16'hABCD;

    // Reset then streaming with decode always ready.
    repeat (3) step(1'b1, 1'b0, 16'h0, 1'b1);
    repeat (8) step(1'b0, 1'b0, 16'h0, 1'b1);
    // Backpressure mid-stream, then release.
    repeat (5) step(1'b0, 1'b0, 16'h0, 1'b0);
    repeat (4) step(1'b0, 1'b0, 16'h0, 1'b1);
    // Redirect while the buffer is full.
    repeat (3) step(1'b0, 1'b0, 16'h0, 1'b0);
    step(1'b0, 1'b1, 16'h0040, 1'b0);
    repeat (4) step(1'b0, 1'b0, 16'h0, 1'b1);
    // Redirect in the same cycle as a would-be transfer.
    step(1'b0, 1'b1, 16'h0080, 1'b1);
    repeat (4) step(1'b0, 1'b0, 16'h0, 1'b1);
    // Address wrap-around.
    step(1'b0, 1'b1, 16'hFFFF, 1'b1);
    repeat (5) step(1'b0, 1'b0, 16'h0, 1'b1);
    // Reset with work buffered and in flight.
    repeat (3) step(1'b0, 1'b0, 16'h0, 1'b0);
    repeat (2) step(1'b1, 1'b0, 16'h0, 1'b0);
    repeat (6) step(1'b0, 1'b0, 16'h0, 1'b1);

    // Randomised traffic.
    for (int n = 0; n < 3000; n++) begin
      r_r = ($urandom_range(99) < 1);
      r_b = ($urandom_range(99) < 5);
      r_y = ($urandom_range(99) < 70);
      r_t = ($urandom_range(3) == 0) ? 16'($urandom_range(16'hFFFF, 16'hFFFC))
                                     : 16'($urandom);
      step(r_r, r_b, r_t, r_y);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_inst_fetch
